// File: rtl/random_lfsr_range.sv
// random_lfsr_range
//   Galois LFSR random source with an optional rejection-sampling front end
//   that returns values uniformly distributed in [0, i_limit).
//
//   Build option: define RANDOM_RANGE_SAMPLER_EN to compile in the IDLE/SAMPLE
//   sampler FSM. Without it, o_value is the low OUT_W state bits captured on
//   i_req, o_valid is i_req delayed one cycle, o_busy is 0 and i_limit is
//   ignored.
//
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset (state -> SEED)
//     i_step       advance the LFSR one step this cycle
//     i_seed_load  load i_seed (zero is replaced by SEED); highest priority
//     i_seed       seed value
//     i_req        request one bounded value
//     i_limit      exclusive upper bound, 0 selects the full 2^OUT_W range
//     o_rng        current LFSR state
//     o_value      bounded result, held between requests
//     o_valid      one-cycle pulse qualifying o_value
//     o_busy       sampler is in SAMPLE
module random_lfsr_range #(
  parameter int                WIDTH     = 9,
  parameter logic [WIDTH-1:0]  TAPS      = 9'h110,
  parameter logic [WIDTH-1:0]  SEED      = WIDTH'(1'b1),
  parameter int                OUT_W     = 5,
  parameter int                MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_step,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_req,
  input  logic [OUT_W-1:0] i_limit,
  output logic [WIDTH-1:0] o_rng,
  output logic [OUT_W-1:0] o_value,
  output logic             o_valid,
  output logic             o_busy
);

  // Try counter value on the final allowed rejection.
  localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES) - 8'd1;

  // One Galois step: shift right, fold the taps in when a one falls out.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    if (s[0]) begin
      lfsr_next = {1'b0, s[WIDTH-1:1]} ^ TAPS;
    end else begin
      lfsr_next = {1'b0, s[WIDTH-1:1]};
    end
  endfunction

  logic [WIDTH-1:0] r_rng;
  logic [OUT_W-1:0] r_value;
  logic             r_valid;

  logic [WIDTH-1:0] w_rng_nxt;
  logic [OUT_W-1:0] w_value_nxt;
  logic             w_valid_nxt;
  logic             w_force_step;
  logic [WIDTH-1:0] w_seed_val;

  // A zero seed would lock the LFSR, so it is swapped for SEED.
  assign w_seed_val = (i_seed == '0) ? SEED : i_seed;

  // LFSR next state: seed load, then sampler-forced step, then i_step.
  always_comb begin
    w_rng_nxt = r_rng;
    if (i_seed_load) begin
      w_rng_nxt = w_seed_val;
    end else if (w_force_step || i_step) begin
      w_rng_nxt = lfsr_next(r_rng);
    end else begin
      w_rng_nxt = r_rng;
    end
  end

`ifdef RANDOM_RANGE_SAMPLER_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_SAMPLE = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OUT_W-1:0] r_limit;
  logic [7:0]       r_tries;
  logic [OUT_W-1:0] w_limit_nxt;
  logic [7:0]       w_tries_nxt;
  logic [OUT_W-1:0] w_cand;
  logic             w_cand_ok;
  logic             w_last_try;

  // Candidate is the state before this cycle's forced step.
  assign w_cand       = r_rng[OUT_W-1:0];
  assign w_cand_ok    = (r_limit == '0) || (w_cand < r_limit);
  assign w_last_try   = (r_tries == LAST_TRY);
  assign w_force_step = (r_state == ST_SAMPLE);

  // Sampler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sampler next state; requests arriving in SAMPLE are dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_req && !i_seed_load) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        if (i_seed_load || w_cand_ok || w_last_try) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SAMPLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sampler outputs: accept, give up with zero, or count another reject.
  always_comb begin
    w_value_nxt = r_value;
    w_valid_nxt = 1'b0;
    w_limit_nxt = r_limit;
    w_tries_nxt = r_tries;
    case (r_state)
      ST_IDLE: begin
        if (i_req && !i_seed_load) begin
          w_limit_nxt = i_limit;
          w_tries_nxt = 8'd0;
        end else begin
          w_tries_nxt = r_tries;
        end
      end
      ST_SAMPLE: begin
        if (i_seed_load) begin
          w_tries_nxt = 8'd0;
        end else if (w_cand_ok) begin
          w_value_nxt = w_cand;
          w_valid_nxt = 1'b1;
        end else if (w_last_try) begin
          w_value_nxt = '0;
          w_valid_nxt = 1'b1;
        end else begin
          w_tries_nxt = r_tries + 8'd1;
        end
      end
      default: begin
        w_tries_nxt = 8'd0;
      end
    endcase
  end

  // Latched bound and try counter for the request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_limit <= '0;
      r_tries <= 8'd0;
    end else begin
      r_limit <= w_limit_nxt;
      r_tries <= w_tries_nxt;
    end
  end

  assign o_busy = (r_state == ST_SAMPLE);
`else
  logic w_unused;

  // Bound and try limit have no meaning without the sampler.
  assign w_unused     = ^{i_limit, LAST_TRY};
  assign w_force_step = 1'b0;

  // Plain mode: capture the pre-step low bits on every request.
  always_comb begin
    w_value_nxt = r_value;
    if (i_req) begin
      w_value_nxt = r_rng[OUT_W-1:0];
    end else begin
      w_value_nxt = r_value;
    end
    w_valid_nxt = i_req;
  end

  assign o_busy = 1'b0;
`endif

  // LFSR state and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rng   <= SEED;
      r_value <= '0;
      r_valid <= 1'b0;
    end else begin
      r_rng   <= w_rng_nxt;
      r_value <= w_value_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign o_rng   = r_rng;
  assign o_value = r_value;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_random_lfsr_range.sv
// Self-checking bench for random_lfsr_range. A transaction-level reference
// model predicts the LFSR sequence and, for each request, the complete
// sampling outcome (latency and result) from the selection rules.
module tb_random_lfsr_range;

  localparam int               WIDTH     = 9;
  localparam logic [WIDTH-1:0] TAPS      = 9'h110;
  localparam logic [WIDTH-1:0] SEED      = 9'h001;
  localparam int               OUT_W     = 5;
  localparam int               MAX_TRIES = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_step;
  logic             i_seed_load;
  logic [WIDTH-1:0] i_seed;
  logic             i_req;
  logic [OUT_W-1:0] i_limit;
  logic [WIDTH-1:0] o_rng;
  logic [OUT_W-1:0] o_value;
  logic             o_valid;
  logic             o_busy;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Reference model state
  int unsigned m_rng;
  int unsigned m_value;
  bit          m_valid;
  bit          m_busy;
`ifdef RANDOM_RANGE_SAMPLER_EN
  int          m_left;
  int unsigned m_result;
`endif

  always #5 clk = ~clk;

  random_lfsr_range #(
    .WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED), .OUT_W(OUT_W), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_step(i_step), .i_seed_load(i_seed_load),
    .i_seed(i_seed), .i_req(i_req), .i_limit(i_limit), .o_rng(o_rng),
    .o_value(o_value), .o_valid(o_valid), .o_busy(o_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned ref_step(input int unsigned s);
    if (s % 2 == 1) return (s / 2) ^ int'(TAPS);
    else return s / 2;
  endfunction

`ifdef RANDOM_RANGE_SAMPLER_EN
  // Whole-request outcome: walk successive candidates until one fits.
  task automatic plan_request(input int unsigned s0, input int unsigned lim,
                              output int cycles, output int unsigned val);
    int unsigned s;
    int unsigned c;
    s = s0;
    cycles = MAX_TRIES;
    val = 0;
    for (int k = 0; k < MAX_TRIES; k++) begin
      c = s % (1 << OUT_W);
      if (lim == 0 || c < lim) begin
        cycles = k + 1;
        val = c;
        return;
      end
      s = ref_step(s);
    end
  endtask
`endif

  task automatic model_reset();
    m_rng   = SEED;
    m_value = 0;
    m_valid = 0;
    m_busy  = 0;
  endtask

  task automatic model_edge();
    int unsigned seed_v;
`ifndef RANDOM_RANGE_SAMPLER_EN
    int unsigned old_rng;
    old_rng = m_rng;
`endif
    seed_v  = (i_seed == 0) ? int'(SEED) : int'(i_seed);
    m_valid = 0;
`ifdef RANDOM_RANGE_SAMPLER_EN
    if (m_busy) begin
      if (i_seed_load) begin
        m_rng  = seed_v;
        m_busy = 0;
      end else begin
        m_rng = ref_step(m_rng);
        m_left--;
        if (m_left == 0) begin
          m_busy  = 0;
          m_valid = 1;
          m_value = m_result;
        end
      end
    end else if (i_seed_load) begin
      m_rng = seed_v;
    end else begin
      if (i_step) m_rng = ref_step(m_rng);
      if (i_req) begin
        plan_request(m_rng, i_limit, m_left, m_result);
        m_busy = 1;
      end
    end
`else
    if (i_seed_load) m_rng = seed_v;
    else if (i_step) m_rng = ref_step(m_rng);
    if (i_req) begin
      m_value = old_rng % (1 << OUT_W);
      m_valid = 1;
    end
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("rng",   o_rng,   m_rng);
    check_eq("valid", o_valid, m_valid);
    check_eq("busy",  o_busy,  m_busy);
    check_eq("value", o_value, m_value);
  endtask

  task automatic drive(input logic step, input logic load, input logic [WIDTH-1:0] seed,
                       input logic req, input logic [OUT_W-1:0] limit);
    i_step = step; i_seed_load = load; i_seed = seed; i_req = req; i_limit = limit;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (o_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic reset_check(input string tag);
    check_eq({tag, "_rng"},   o_rng,   SEED);
    check_eq({tag, "_value"}, o_value, 0);
    check_eq({tag, "_valid"}, o_valid, 0);
    check_eq({tag, "_busy"},  o_busy,  0);
  endtask

  initial begin
    int unsigned exp_seq[3] = '{32'h110, 32'h088, 32'h044};
    bit          seen[512];
    int          n_valid;
    int          lat;
    int unsigned sseed;
    int unsigned x;
    bit          found;
    bit          ok;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    model_reset();
    #12;
    reset_check("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Known first steps of the default polynomial
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("seq_const", o_rng, exp_seq[k]);
    end

    // Zero seed load beats i_step and is replaced by SEED
    drive(1'b1, 1'b1, '0, 1'b0, '0);
    cycle();
    check_eq("seed_zero", o_rng, 32'h001);

    // Full period: 511 distinct nonzero states, then back to the start
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    foreach (seen[i]) seen[i] = 1'b0;
    seen[1] = 1'b1;
    for (int k = 1; k <= 511; k++) begin
      cycle();
      check_eq("period_nonzero", (o_rng != 0), 1);
      if (k < 511) begin
        check_eq("period_fresh", seen[o_rng], 0);
        seen[o_rng] = 1'b1;
      end else begin
        check_eq("period_return", o_rng, 32'h001);
      end
    end

    // 1000 back-to-back requests with limit 20
    n_valid = 0;
    for (int c = 0; c < 40000 && n_valid < 1000; c++) begin
      drive(1'($urandom_range(0, 1)), 1'b0, '0, 1'b1, 5'd20);
      cycle();
      if (o_valid) begin
        n_valid++;
`ifdef RANDOM_RANGE_SAMPLER_EN
        check_eq("bounded_lt20", (o_value < 20), 1);
`endif
      end
    end
    check_eq("req_count", n_valid, 1000);
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    repeat (20) cycle();

`ifdef RANDOM_RANGE_SAMPLER_EN
    // Find a seed whose next 16 states all have nonzero low bits
    found = 1'b0;
    sseed = 1;
    for (int s = 1; s < 512 && !found; s++) begin
      x = s;
      ok = 1'b1;
      for (int j = 0; j < MAX_TRIES; j++) begin
        if (x % (1 << OUT_W) == 0) ok = 1'b0;
        x = ref_step(x);
      end
      if (ok) begin
        found = 1'b1;
        sseed = s;
      end
    end
    check_eq("seed_found", found, 1);

    // Full-range request gives the seed's low bits one cycle after entry
    drive(1'b0, 1'b1, WIDTH'(sseed), 1'b0, '0);
    cycle();
    drive(1'b0, 1'b0, '0, 1'b1, 5'd0);
    cycle();
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    wait_valid(lat);
    check_eq("full_lat", lat, 1);
    check_eq("full_value", o_value, sseed % 32);

    // limit=1 with no zero candidate: give up after 16 tries with 0
    drive(1'b0, 1'b1, WIDTH'(sseed), 1'b0, '0);
    cycle();
    drive(1'b0, 1'b0, '0, 1'b1, 5'd1);
    cycle();
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    wait_valid(lat);
    check_eq("fallback_lat", lat, MAX_TRIES);
    check_eq("fallback_value", o_value, 0);
    cycle();
    check_eq("valid_pulse", o_valid, 0);
`endif

    // Seed load mid-request aborts it
    drive(1'b0, 1'b1, 9'h0a5, 1'b0, '0);
    cycle();
    drive(1'b0, 1'b0, '0, 1'b1, 5'd1);
    cycle();
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    repeat (2) cycle();
    drive(1'b0, 1'b1, 9'h133, 1'b0, '0);
    cycle();
    check_eq("abort_busy", o_busy, 0);
    check_eq("abort_valid", o_valid, 0);
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    repeat (MAX_TRIES + 2) cycle();

    // Asynchronous reset mid-request
    drive(1'b1, 1'b0, '0, 1'b1, 5'd1);
    cycle();
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    repeat (2) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    reset_check("async_rst");
    model_reset();
    @(posedge clk); #1;
    reset_check("rst_hold");
    rst_n = 1'b1;
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    cycle();
    check_eq("post_rst_step", o_rng, 32'h110);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 31) == 0),
            ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom),
            1'($urandom_range(0, 3) == 0),
            OUT_W'($urandom));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
